// File: rtl/modulation_scaler_if.sv
// modulation_scaler_if: request, result and status signals of the duty scaler.
interface modulation_scaler_if #(
    parameter int unsigned WIDTH   = 13,
    parameter int unsigned DEPTH   = 249,
    parameter int unsigned M_WIDTH = 8
);
    logic               start;
    logic [M_WIDTH-1:0] m;
    logic [WIDTH-1:0]   duty_in  [DEPTH];
    logic [WIDTH-1:0]   duty_out [DEPTH];
    logic               busy;
    logic               done;

    modport master (output start, m, duty_in, input duty_out, busy, done);
    modport slave  (input start, m, duty_in, output duty_out, busy, done);
endinterface

// File: rtl/modulation_scaler.sv
// modulation_scaler: scales DEPTH duty values by M/MMAX, LANES elements per cycle,
// through a fixed 4-cycle pipeline. Division by MMAX = 2^M_WIDTH-1 is exact and
// done by folding the high digit back onto the low digit (x mod MMAX is preserved).
// Macro MODULATION_SCALER_ROUNDING_EN: round half up instead of truncating floor.
module modulation_scaler #(
    parameter int unsigned WIDTH   = 13,
    parameter int unsigned DEPTH   = 249,
    parameter int unsigned M_WIDTH = 8,
    parameter int unsigned LANES   = 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    modulation_scaler_if.slave io_bus
);
    localparam int unsigned GROUPS = DEPTH / LANES;
    localparam int unsigned GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int unsigned IW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PW     = WIDTH + M_WIDTH;
    localparam int unsigned NF     = (PW + M_WIDTH - 1) / M_WIDTH + 1;
    localparam logic [PW-1:0] MMAX = PW'({M_WIDTH{1'b1}});
`ifdef MODULATION_SCALER_ROUNDING_EN
    // floor((2p+MMAX)/(2*MMAX)) == floor((p + (MMAX>>1)) / MMAX) because MMAX is odd
    localparam logic [PW-1:0] HALF = MMAX >> 1;
`endif

    if ((DEPTH % LANES) != 0) begin : g_lanes_check
        $error("modulation_scaler: DEPTH must be a multiple of LANES");
    end

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DRAIN} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [GW-1:0]      r_grp;
    logic [GW-1:0]      w_grp_nxt;
    logic               r_busy;
    logic               r_done;
    logic               w_done_nxt;
    logic               w_accept;
    logic               w_issue;
    logic               w_last;

    logic [M_WIDTH-1:0] r_m;
    logic [WIDTH-1:0]   r_duty     [DEPTH];
    logic [WIDTH-1:0]   r_duty_out [DEPTH];

    logic               r_v1, r_v2, r_v3, r_v4;
    logic               r_l1, r_l2, r_l3, r_l4;
    logic [GW-1:0]      r_g1, r_g2, r_g3, r_g4;
    logic [PW-1:0]      w_p1 [LANES];
    logic [PW-1:0]      r_p1 [LANES];
    logic [PW-1:0]      w_q2 [LANES];
    logic [PW-1:0]      w_x2 [LANES];
    logic [PW-1:0]      r_q2 [LANES];
    logic [PW-1:0]      r_x2 [LANES];
    logic [PW-1:0]      w_q3 [LANES];
    logic [PW-1:0]      w_x3 [LANES];
    logic [PW-1:0]      r_q3 [LANES];
    logic [PW-1:0]      r_x3 [LANES];
    logic [WIDTH-1:0]   w_q4 [LANES];
    logic [WIDTH-1:0]   r_q4 [LANES];

    function automatic logic [IW-1:0] elem_idx(input logic [GW-1:0] grp, input int unsigned lane);
        return IW'(32'(grp) * LANES + lane);
    endfunction

    // n folds of x = hi + lo, accumulating hi into the quotient; returns {q, x}
    function automatic logic [2*PW-1:0] fold(input logic [PW-1:0] x_in,
                                             input logic [PW-1:0] q_in,
                                             input int unsigned n);
        logic [PW-1:0] x;
        logic [PW-1:0] q;
        logic [PW-1:0] hi;
        x = x_in;
        q = q_in;
        for (int unsigned f = 0; f < n; f++) begin
            hi = x >> M_WIDTH;
            q  = q + hi;
            x  = hi + (x & MMAX);
        end
        return {q, x};
    endfunction

    // Next-state and control: accept, issue one lane group per CALC cycle, wait for last retire
    always_comb begin
        w_state_nxt = r_state;
        w_grp_nxt   = r_grp;
        w_accept    = 1'b0;
        w_issue     = 1'b0;
        w_last      = 1'b0;
        w_done_nxt  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (io_bus.start) begin
                    w_accept    = 1'b1;
                    w_grp_nxt   = '0;
                    w_state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                w_issue = 1'b1;
                if (r_grp == GW'(GROUPS - 1)) begin
                    w_last      = 1'b1;
                    w_state_nxt = S_DRAIN;
                end else begin
                    w_grp_nxt = r_grp + 1'b1;
                end
            end
            S_DRAIN: begin
                if (r_v4 && r_l4) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State, group counter and status flags
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_grp   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_grp   <= w_grp_nxt;
            r_busy  <= (r_state != S_IDLE) && (w_state_nxt != S_IDLE);
            r_done  <= w_done_nxt;
        end
    end

    // Snapshot of the pass operands; the running pass never looks at the live inputs
    always_ff @(posedge i_clk) begin
        if (w_accept && !i_rst) begin
            r_duty <= io_bus.duty_in;
            r_m    <= io_bus.m;
        end
    end

    // Datapath: product, first fold, remaining folds, final single correction
    always_comb begin
        for (int unsigned l = 0; l < LANES; l++) begin
`ifdef MODULATION_SCALER_ROUNDING_EN
            w_p1[l] = PW'(r_duty[elem_idx(r_grp, l)]) * PW'(r_m) + HALF;
`else
            w_p1[l] = PW'(r_duty[elem_idx(r_grp, l)]) * PW'(r_m);
`endif
            {w_q2[l], w_x2[l]} = fold(r_p1[l], '0, 1);
            {w_q3[l], w_x3[l]} = fold(r_x2[l], r_q2[l], NF - 1);
            w_q4[l] = WIDTH'(r_q3[l] + ((r_x3[l] >= MMAX) ? PW'(1) : PW'(0)));
        end
    end

    // Pipeline valid flags; cleared on reset so in-flight data is dropped
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
            r_v4 <= 1'b0;
        end else begin
            r_v1 <= w_issue;
            r_v2 <= r_v1;
            r_v3 <= r_v2;
            r_v4 <= r_v3;
        end
    end

    // Pipeline payload and tags
    always_ff @(posedge i_clk) begin
        r_l1 <= w_last;
        r_l2 <= r_l1;
        r_l3 <= r_l2;
        r_l4 <= r_l3;
        r_g1 <= r_grp;
        r_g2 <= r_g1;
        r_g3 <= r_g2;
        r_g4 <= r_g3;
        r_p1 <= w_p1;
        r_q2 <= w_q2;
        r_x2 <= w_x2;
        r_q3 <= w_q3;
        r_x3 <= w_x3;
        r_q4 <= w_q4;
    end

    // Result bank: each element keeps its value until its lane group retires
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) r_duty_out[i] <= '0;
        end else if (r_v4) begin
            for (int unsigned l = 0; l < LANES; l++) r_duty_out[elem_idx(r_g4, l)] <= r_q4[l];
        end
    end

    assign io_bus.duty_out = r_duty_out;
    assign io_bus.busy     = r_busy;
    assign io_bus.done     = r_done;
endmodule

// File: tb/tb_modulation_scaler.sv
// tb_modulation_scaler: scoreboard bench for the duty scaler, LANES=1 and LANES=3 instances.
module tb_modulation_scaler;
    localparam int unsigned WIDTH   = 13;
    localparam int unsigned DEPTH   = 249;
    localparam int unsigned M_WIDTH = 8;
    localparam int unsigned N1      = DEPTH;
    localparam int unsigned N3      = DEPTH / 3;
`ifdef MODULATION_SCALER_ROUNDING_EN
    localparam int unsigned EXP_D0_M200 = 1;
`else
    localparam int unsigned EXP_D0_M200 = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    modulation_scaler_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .M_WIDTH(M_WIDTH)) b1 ();
    modulation_scaler_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .M_WIDTH(M_WIDTH)) b3 ();

    modulation_scaler #(.WIDTH(WIDTH), .DEPTH(DEPTH), .M_WIDTH(M_WIDTH), .LANES(1)) u1 (
        .i_clk(clk), .i_rst(rst), .io_bus(b1)
    );
    modulation_scaler #(.WIDTH(WIDTH), .DEPTH(DEPTH), .M_WIDTH(M_WIDTH), .LANES(3)) u3 (
        .i_clk(clk), .i_rst(rst), .io_bus(b3)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int unsigned sb1[$];
    int unsigned sb3[$];
    int unsigned prev0 = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int unsigned model(input int unsigned d, input int unsigned m);
`ifdef MODULATION_SCALER_ROUNDING_EN
        return (2 * d * m + 255) / (2 * 255);
`else
        return (d * m) / 255;
`endif
    endfunction

    task automatic fill1(input bit rnd, input logic [WIDTH-1:0] val);
        for (int i = 0; i < DEPTH; i++) b1.duty_in[i] = rnd ? WIDTH'($urandom) : val;
    endtask

    function automatic int count_nonzero1();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) if (b1.duty_out[i] !== '0) n++;
        return n;
    endfunction

    // One LANES=1 pass: optional mid-pass START/input changes, optional START on the DONE edge
    task automatic run_pass(input string tag, input logic [M_WIDTH-1:0] mval,
                            input bit disturb, input bit start_at_done);
        int unsigned exp0;
        bit          seen;
        bit          busy_ok;
        int          k;
        int unsigned e;
        @(negedge clk);
        b1.m     = mval;
        b1.start = 1'b1;
        for (int i = 0; i < DEPTH; i++) sb1.push_back(model(32'(b1.duty_in[i]), 32'(mval)));
        exp0 = model(32'(b1.duty_in[0]), 32'(mval));
        @(posedge clk); #1;
        b1.start = 1'b0;
        check({tag, "_busy_t0"}, 32'(b1.busy), 32'd0);
        seen    = 1'b0;
        busy_ok = 1'b1;
        k       = 0;
        while (!seen && k < int'(N1) + 20) begin
            @(posedge clk); #1;
            k++;
            b1.start = 1'b0;
            if (k == 4) check({tag, "_hold_d0"}, 32'(b1.duty_out[0]), prev0);
            if (k == 5) check({tag, "_first_d0"}, 32'(b1.duty_out[0]), exp0);
            if (b1.done) begin
                seen = 1'b1;
                check({tag, "_done_cycle"}, 32'(k), 32'(N1 + 4));
                check({tag, "_busy_at_done"}, 32'(b1.busy), 32'd0);
            end else if (b1.busy !== 1'b1) begin
                busy_ok = 1'b0;
            end
            if (disturb && (k == 9 || k == 99)) begin
                b1.start = 1'b1;
                b1.m     = M_WIDTH'($urandom);
                fill1(1'b1, '0);
            end
            if (start_at_done && k == int'(N1) + 3) b1.start = 1'b1;
        end
        if (!seen) check({tag, "_done_timeout"}, 32'd0, 32'd1);
        check({tag, "_busy_window"}, 32'(busy_ok), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            e = sb1.pop_front();
            check($sformatf("%s_out%0d", tag, i), 32'(b1.duty_out[i]), e);
        end
        prev0 = exp0;
        if (!start_at_done) begin
            @(posedge clk); #1;
            check({tag, "_done_pulse_end"}, 32'(b1.done), 32'd0);
            check({tag, "_idle_after"}, 32'(b1.busy), 32'd0);
        end
    endtask

    // One LANES=3 pass with random duties and M
    task automatic run_pass3(input string tag);
        logic [M_WIDTH-1:0] mv;
        bit                 seen;
        int                 k;
        int unsigned        e;
        mv = M_WIDTH'($urandom);
        for (int i = 0; i < DEPTH; i++) b3.duty_in[i] = WIDTH'($urandom);
        @(negedge clk);
        b3.m     = mv;
        b3.start = 1'b1;
        for (int i = 0; i < DEPTH; i++) sb3.push_back(model(32'(b3.duty_in[i]), 32'(mv)));
        @(posedge clk); #1;
        b3.start = 1'b0;
        seen = 1'b0;
        k    = 0;
        while (!seen && k < int'(N3) + 20) begin
            @(posedge clk); #1;
            k++;
            if (b3.done) begin
                seen = 1'b1;
                check({tag, "_done_cycle"}, 32'(k), 32'(N3 + 4));
            end
        end
        if (!seen) check({tag, "_done_timeout"}, 32'd0, 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            e = sb3.pop_front();
            check($sformatf("%s_out%0d", tag, i), 32'(b3.duty_out[i]), e);
        end
    endtask

    initial begin
        int  nz;
        bit  quiet;
        b1.start = 1'b0;
        b1.m     = '0;
        b3.start = 1'b0;
        b3.m     = '0;
        fill1(1'b0, '0);
        for (int i = 0; i < DEPTH; i++) b3.duty_in[i] = '0;

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(b1.busy), 32'd0);
        check("rst_done", 32'(b1.done), 32'd0);
        check("rst_out_first", 32'(b1.duty_out[0]), 32'd0);
        check("rst_out_last", 32'(b1.duty_out[DEPTH-1]), 32'd0);
        check("rst_busy_l3", 32'(b3.busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Basic scaling and boundary factors
        fill1(1'b0, WIDTH'(4096));
        run_pass("half", M_WIDTH'(128), 1'b0, 1'b0);
        check("half_value", 32'(b1.duty_out[100]), 32'd2056);
        fill1(1'b0, WIDTH'(8191));
        run_pass("mfull", M_WIDTH'(255), 1'b0, 1'b0);
        check("mfull_value", 32'(b1.duty_out[7]), 32'd8191);
        run_pass("mzero", M_WIDTH'(0), 1'b0, 1'b0);
        check("mzero_value", 32'(b1.duty_out[7]), 32'd0);

        // Small duty where floor and rounding differ
        fill1(1'b1, '0);
        b1.duty_in[0] = WIDTH'(1);
        run_pass("m200", M_WIDTH'(200), 1'b0, 1'b0);
        check("m200_d0", 32'(b1.duty_out[0]), EXP_D0_M200);

        // START and input changes while busy are ignored
        fill1(1'b1, '0);
        run_pass("disturb", M_WIDTH'($urandom), 1'b1, 1'b0);

        // START on the DONE edge ignored; START one cycle later accepted
        fill1(1'b1, '0);
        run_pass("chain_a", M_WIDTH'($urandom), 1'b0, 1'b1);
        fill1(1'b1, '0);
        run_pass("chain_b", M_WIDTH'($urandom), 1'b0, 1'b0);

        // Reset wins over START on the same edge
        @(negedge clk);
        rst      = 1'b1;
        b1.start = 1'b1;
        @(posedge clk); #1;
        rst      = 1'b0;
        b1.start = 1'b0;
        @(posedge clk); #1;
        check("rst_prio_busy", 32'(b1.busy), 32'd0);
        prev0 = 0;

        // Reset mid-pass aborts without DONE or late writes
        fill1(1'b1, '0);
        @(negedge clk);
        b1.m     = M_WIDTH'(77);
        b1.start = 1'b1;
        @(posedge clk); #1;
        b1.start = 1'b0;
        for (int k = 1; k < 100; k++) begin
            @(posedge clk); #1;
            if (k == 99) rst = 1'b1;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        check("rstmid_busy", 32'(b1.busy), 32'd0);
        check("rstmid_done", 32'(b1.done), 32'd0);
        nz = count_nonzero1();
        check("rstmid_outs_zero", 32'(nz), 32'd0);
        quiet = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (b1.done !== 1'b0 || b1.busy !== 1'b0 || count_nonzero1() != 0) quiet = 1'b0;
        end
        check("rstmid_quiet", 32'(quiet), 32'd1);
        fill1(1'b1, '0);
        run_pass("after_rst", M_WIDTH'($urandom), 1'b0, 1'b0);

        // Three lanes per cycle
        run_pass3("l3_a");
        run_pass3("l3_b");
        run_pass3("l3_c");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/modulation_scaler.md
MODULATION_SCALER -- requirements
Module: modulation_scaler

Interface
REQ-001 Parameter WIDTH, default 13: bit width of each duty element.
REQ-002 Parameter DEPTH, default 249: number of duty elements (transducers).
REQ-003 Parameter M_WIDTH, default 8: bit width of modulation factor M; full scale MMAX = 2^M_WIDTH-1.
REQ-004 Parameter LANES, default 1: elements processed per cycle; DEPTH % LANES == 0, checked by an elaboration-time assertion.
REQ-005 CLK  input  1  sole clock; all logic on rising edge.
REQ-006 RST  input  1  reset, synchronous, active-high.
REQ-007 START  input  1  request one scaling pass; honoured only in IDLE.
REQ-008 M  input  M_WIDTH  unsigned modulation factor; sampled only at START acceptance.
REQ-009 DUTY_IN  input  WIDTH x DEPTH array  unsigned source duties; sampled only at START acceptance.
REQ-010 DUTY_OUT  output  WIDTH x DEPTH array  registered scaled duties.
REQ-011 BUSY  output  1  high while a pass is in progress.
REQ-012 DONE  output  1  one-cycle pulse on pass completion.

Function
REQ-013 FSM states: IDLE, CALC, DRAIN; reset state IDLE.
REQ-014 IDLE: START=1 at edge T0 latches all DUTY_IN and M into internal registers and enters CALC; BUSY=1 from T0+1.
REQ-015 CALC: issue LANES consecutive elements per cycle (index k*LANES..k*LANES+LANES-1) into the pipeline; after DEPTH/LANES cycles enter DRAIN.
REQ-016 Pipeline latency is fixed at 4 cycles from issue to DUTY_OUT write; the latched M is used for the whole pass (no per-cycle resampling).
REQ-017 DRAIN: wait for the last lane group to retire, then return to IDLE.
REQ-018 DONE=1 for exactly one cycle at edge T0 + DEPTH/LANES + 4; BUSY drops on the same edge.
REQ-019 Arithmetic (default): DUTY_OUT[i] = floor(duty[i]*M / MMAX), exact for all inputs; no divider IP, constant-reciprocal multiply or equivalent.
REQ-020 Intermediate product width is WIDTH+M_WIDTH bits, with no overflow; the result always satisfies DUTY_OUT[i] <= duty[i].
REQ-021 Boundaries: M=0 -> all outputs 0; M=MMAX -> DUTY_OUT[i]=duty[i] exactly.
REQ-022 Each DUTY_OUT element holds its previous value until overwritten by its pipeline result; all elements are final when DONE=1.
REQ-023 START while BUSY=1 is ignored, with no effect on the running pass; DUTY_IN/M changes during the pass have no effect.
REQ-024 START on the same cycle as DONE is ignored; START one cycle after DONE is accepted.

Reset
REQ-025 RST=1 at any edge: state IDLE, BUSY=0, DONE=0, all DUTY_OUT=0, pipeline valid flags cleared.
REQ-026 RST mid-pass aborts the pass; no DONE pulse for it, and no DUTY_OUT write from in-flight data after reset.
REQ-027 RST has priority over START on the same edge.

Configuration
REQ-028 Macro MODULATION_SCALER_ROUNDING_EN defined: DUTY_OUT[i] = floor((2*duty[i]*M + MMAX) / (2*MMAX)), i.e. round half up; latency unchanged.
REQ-029 Macro undefined: truncating floor per REQ-019; no rounding logic is instantiated.

Verification (WIDTH=13, DEPTH=249, M_WIDTH=8 unless stated)
REQ-030 LANES=1, all duty=4096, M=128, START at T0 -> DONE single pulse at T0+253, all DUTY_OUT=2056, BUSY high T0+1..T0+252.
REQ-031 duty[i]=8191 and M=255 -> all 8191; same duties with M=0 -> all 0.
REQ-032 duty[0]=1, M=200 -> DUTY_OUT[0]=0 without the macro, 1 with MODULATION_SCALER_ROUNDING_EN.
REQ-033 LANES=3, random duties and M -> DONE at T0+87, every element matching the reference model.
REQ-034 START pulses at T0+10 and T0+100 with changed DUTY_IN/M -> only one DONE, and results reflect T0 inputs.
REQ-035 RST at T0+100 -> BUSY=0 and DUTY_OUT all 0 next cycle; no DONE; a new START then completes normally.
